// File: rtl/spi_frame_assembler.sv
// rtl/spi_frame_assembler.sv - SPI byte stream to framed command packet assembler
module spi_frame_assembler #(
    parameter int         NUM_WORDS = 5,
    parameter logic [7:0] HEADER    = 8'hA5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      spi_cs,
    input  logic [7:0]                rx_byte,
    input  logic                      rx_ready,
    output logic                      frame_valid,
    input  logic                      frame_ready,
    output logic [7:0]                opcode,
    output logic [32*NUM_WORDS-1:0]   payload,
    output logic                      chk_err,
    output logic                      abort,
    output logic                      overrun
);

    localparam int NB = 4 * NUM_WORDS;
    localparam int CW = $clog2(NB);
    localparam int PW = 32 * NUM_WORDS;
    localparam logic [CW-1:0] LAST_IDX = CW'(NB - 1);
    localparam logic [CW-1:0] SWAP     = CW'(3);

    typedef enum logic [2:0] {
        S_IDLE,
        S_OPCODE,
        S_PAYLOAD,
        S_CHECK,
        S_HOLD
    } state_t;

    logic rdy_meta_q, rdy_sync_q, rdy_prev_q;
    logic cs_meta_q, cs_sync_q, cs_prev_q;
    logic byte_ev, cs_rise;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [7:0]       csum_q, csum_d;
    logic [7:0]       opcode_q, opcode_d;
    logic [PW-1:0]    payload_q, payload_d;
    logic             chk_err_q, chk_err_d;
    logic             abort_q, abort_d;
    logic             overrun_q, overrun_d;
    logic [CW+2:0]    bit_off;

    always_ff @(posedge clk) begin
        if (rst) begin
            rdy_meta_q <= 1'b0;
            rdy_sync_q <= 1'b0;
            rdy_prev_q <= 1'b0;
            cs_meta_q  <= 1'b1;
            cs_sync_q  <= 1'b1;
            cs_prev_q  <= 1'b1;
        end else begin
            rdy_meta_q <= rx_ready;
            rdy_sync_q <= rdy_meta_q;
            rdy_prev_q <= rdy_sync_q;
            cs_meta_q  <= spi_cs;
            cs_sync_q  <= cs_meta_q;
            cs_prev_q  <= cs_sync_q;
        end
    end

    assign byte_ev = rdy_sync_q & ~rdy_prev_q;
    assign cs_rise = cs_sync_q & ~cs_prev_q;

    // Byte k lands at bit 8*(k^3): word k/4, most significant byte first.
    assign bit_off = {cnt_q ^ SWAP, 3'b000};

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        csum_d    = csum_q;
        opcode_d  = opcode_q;
        payload_d = payload_q;
        chk_err_d = 1'b0;
        abort_d   = 1'b0;
        overrun_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (byte_ev && rx_byte == HEADER) begin
                    state_d = S_OPCODE;
                    cnt_d   = '0;
                end
            end
            S_OPCODE: begin
                if (cs_rise) begin
                    abort_d = 1'b1;
                    state_d = S_IDLE;
                end else if (byte_ev) begin
                    opcode_d = rx_byte;
                    csum_d   = rx_byte;
                    cnt_d    = '0;
                    state_d  = S_PAYLOAD;
                end
            end
            S_PAYLOAD: begin
                if (cs_rise) begin
                    abort_d = 1'b1;
                    state_d = S_IDLE;
                end else if (byte_ev) begin
                    payload_d[bit_off +: 8] = rx_byte;
                    csum_d = csum_q ^ rx_byte;
                    if (cnt_q == LAST_IDX) begin
                        state_d = S_CHECK;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_CHECK: begin
                if (cs_rise) begin
                    abort_d = 1'b1;
                    state_d = S_IDLE;
                end else if (byte_ev) begin
                    if (rx_byte == csum_q) begin
                        state_d = S_HOLD;
                    end else begin
                        chk_err_d = 1'b1;
                        state_d   = S_IDLE;
                    end
                end
            end
            S_HOLD: begin
                overrun_d = byte_ev;
                if (frame_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            csum_q    <= '0;
            opcode_q  <= '0;
            payload_q <= '0;
            chk_err_q <= 1'b0;
            abort_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            csum_q    <= csum_d;
            opcode_q  <= opcode_d;
            payload_q <= payload_d;
            chk_err_q <= chk_err_d;
            abort_q   <= abort_d;
            overrun_q <= overrun_d;
        end
    end

    assign frame_valid = (state_q == S_HOLD);
    assign opcode      = opcode_q;
    assign payload     = payload_q;
    assign chk_err     = chk_err_q;
    assign abort       = abort_q;
    assign overrun     = overrun_q;

endmodule

// File: tb/tb_spi_frame_assembler.sv
// tb/tb_spi_frame_assembler.sv - randomized self-checking bench for spi_frame_assembler
module tb_spi_frame_assembler;

    localparam int         NW  = 5;
    localparam int         PW  = 32 * NW;
    localparam logic [7:0] HDR = 8'hA5;

    logic          clk = 1'b0;
    logic          rst, spi_cs, rx_ready, frame_ready;
    logic [7:0]    rx_byte;
    logic          frame_valid, chk_err, abort, overrun;
    logic [7:0]    opcode;
    logic [PW-1:0] payload;

    int tests_run = 0;
    int failed    = 0;

    always #5 clk = ~clk;

    spi_frame_assembler #(.NUM_WORDS(NW), .HEADER(HDR)) dut (
        .clk         (clk),
        .rst         (rst),
        .spi_cs      (spi_cs),
        .rx_byte     (rx_byte),
        .rx_ready    (rx_ready),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready),
        .opcode      (opcode),
        .payload     (payload),
        .chk_err     (chk_err),
        .abort       (abort),
        .overrun     (overrun)
    );

    // Observer: counts pulses, records transferred frames, flags protocol breaches.
    int n_chk = 0, n_abort = 0, n_ovr = 0, n_vcyc = 0;
    int n_wid_err = 0, n_stab_err = 0, n_drop_err = 0;
    logic [7:0]    got_op[$];
    logic [PW-1:0] got_pl[$];
    logic          p_valid = 0, p_ready = 0, p_chk = 0, p_abort = 0, p_ovr = 0;
    logic [7:0]    p_op = 0;
    logic [PW-1:0] p_pl = 0;

    always @(negedge clk) begin
        if (rst) begin
            p_valid = 0; p_ready = 0; p_chk = 0; p_abort = 0; p_ovr = 0;
        end else begin
            if (chk_err) n_chk++;
            if (abort) n_abort++;
            if (overrun) n_ovr++;
            if (frame_valid) n_vcyc++;
            if ((chk_err && p_chk) || (abort && p_abort) || (overrun && p_ovr)) n_wid_err++;
            if (frame_valid && p_valid && !p_ready && (opcode !== p_op || payload !== p_pl)) n_stab_err++;
            if (frame_valid && p_valid && p_ready) n_drop_err++;
            if (frame_valid && frame_ready) begin
                got_op.push_back(opcode);
                got_pl.push_back(payload);
            end
            p_valid = frame_valid; p_ready = frame_ready; p_chk = chk_err;
            p_abort = abort; p_ovr = overrun; p_op = opcode; p_pl = payload;
        end
    end

    int b_chk, b_abort, b_ovr, b_vcyc, b_frames;
    int rd_idx = 0;
    logic [7:0] tx_q[$];

    task automatic snap();
        b_chk = n_chk; b_abort = n_abort; b_ovr = n_ovr; b_vcyc = n_vcyc; b_frames = got_op.size();
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_byte  = b;
        rx_ready = 1'b1;
        tick(4);
        rx_ready = 1'b0;
        tick(4);
    endtask

    task automatic send_q();
        while (tx_q.size() > 0) send_byte(tx_q.pop_front());
    endtask

    // Frame as seen on the wire: header, opcode, words MSB first, XOR checksum (optionally corrupted).
    task automatic push_frame(input logic [7:0] op, input logic [PW-1:0] pl, input logic [7:0] corrupt);
        logic [7:0]  c, b;
        logic [31:0] w;
        c = op;
        tx_q.push_back(HDR);
        tx_q.push_back(op);
        for (int i = 0; i < NW; i++) begin
            w = pl[32*i +: 32];
            for (int j = 0; j < 4; j++) begin
                b = w[31-8*j -: 8];
                c = c ^ b;
                tx_q.push_back(b);
            end
        end
        tx_q.push_back(c ^ corrupt);
    endtask

    function automatic logic [PW-1:0] rand_pl();
        logic [PW-1:0] r;
        for (int i = 0; i < NW; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    task automatic wait_frames(input int n);
        int k;
        k = 0;
        while (got_op.size() < n && k < 200) begin
            tick(1);
            k++;
        end
    endtask

    task automatic wait_valid();
        int k;
        k = 0;
        while (!frame_valid && k < 200) begin
            tick(1);
            k++;
        end
    endtask

    task automatic test_reset();
        rst = 1; spi_cs = 0; rx_ready = 0; rx_byte = 0; frame_ready = 1;
        tick(3);
        @(negedge clk);
        tests_run++; if (frame_valid !== 1'b0) begin failed++; $display("FAIL reset_valid: got %b expected 0", frame_valid); end
        tests_run++; if (chk_err !== 1'b0) begin failed++; $display("FAIL reset_chk_err: got %b expected 0", chk_err); end
        tests_run++; if (abort !== 1'b0) begin failed++; $display("FAIL reset_abort: got %b expected 0", abort); end
        tests_run++; if (overrun !== 1'b0) begin failed++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
        tests_run++; if (opcode !== 8'h00) begin failed++; $display("FAIL reset_opcode: got %h expected 00", opcode); end
        tests_run++; if (payload !== '0) begin failed++; $display("FAIL reset_payload: got %h expected 0", payload); end
        tick(1);
        rst = 0;
        tick(4);
    endtask

    task automatic test_good_frame();
        logic [PW-1:0] pl;
        snap();
        frame_ready = 1;
        for (int k = 0; k < 4*NW; k++) pl[32*(k/4) + 8*(3 - k%4) +: 8] = 8'(k);
        push_frame(8'h01, pl, 8'h00);
        send_q();
        wait_frames(b_frames + 1);
        tick(3);
        tests_run++;
        if (got_op.size() !== b_frames + 1) begin
            failed++; $display("FAIL good_count: got %0d expected %0d", got_op.size() - b_frames, 1);
        end else begin
            tests_run++; if (got_op[rd_idx] !== 8'h01) begin failed++; $display("FAIL good_opcode: got %h expected 01", got_op[rd_idx]); end
            tests_run++; if (got_pl[rd_idx][31:0] !== 32'h00010203) begin failed++; $display("FAIL good_word0: got %h expected 00010203", got_pl[rd_idx][31:0]); end
            tests_run++; if (got_pl[rd_idx][159:128] !== 32'h10111213) begin failed++; $display("FAIL good_word4: got %h expected 10111213", got_pl[rd_idx][159:128]); end
            rd_idx = got_op.size();
        end
        tests_run++; if (n_vcyc - b_vcyc !== 1) begin failed++; $display("FAIL good_valid_cycles: got %0d expected 1", n_vcyc - b_vcyc); end
        tests_run++; if (n_chk + n_abort + n_ovr - b_chk - b_abort - b_ovr !== 0) begin failed++; $display("FAIL good_no_pulses: got %0d expected 0", n_chk + n_abort + n_ovr - b_chk - b_abort - b_ovr); end
    endtask

    task automatic test_bad_checksum();
        logic [PW-1:0] pl;
        logic [7:0]    op;
        snap();
        frame_ready = 1;
        for (int k = 0; k < 4*NW; k++) pl[32*(k/4) + 8*(3 - k%4) +: 8] = 8'(k);
        push_frame(8'h01, pl, 8'h03);
        send_q();
        tick(4);
        tests_run++; if (n_chk - b_chk !== 1) begin failed++; $display("FAIL bad_chk_pulses: got %0d expected 1", n_chk - b_chk); end
        tests_run++; if (n_vcyc - b_vcyc !== 0) begin failed++; $display("FAIL bad_valid_cycles: got %0d expected 0", n_vcyc - b_vcyc); end
        op = 8'($urandom);
        pl = rand_pl();
        push_frame(op, pl, 8'h00);
        send_q();
        wait_frames(b_frames + 1);
        tests_run++;
        if (got_op.size() !== b_frames + 1) begin
            failed++; $display("FAIL bad_then_good_count: got %0d expected 1", got_op.size() - b_frames);
        end else begin
            tests_run++; if (got_op[rd_idx] !== op) begin failed++; $display("FAIL bad_then_good_opcode: got %h expected %h", got_op[rd_idx], op); end
            tests_run++; if (got_pl[rd_idx] !== pl) begin failed++; $display("FAIL bad_then_good_payload: got %h expected %h", got_pl[rd_idx], pl); end
            rd_idx = got_op.size();
        end
        tests_run++; if (n_chk - b_chk !== 1) begin failed++; $display("FAIL bad_then_good_chk: got %0d expected 1", n_chk - b_chk); end
    endtask

    task automatic test_back_pressure();
        logic [PW-1:0] pl;
        logic [7:0]    op;
        snap();
        frame_ready = 0;
        op = 8'($urandom);
        pl = rand_pl();
        push_frame(op, pl, 8'h00);
        send_q();
        wait_valid();
        send_byte(HDR);
        send_byte(8'($urandom));
        spi_cs = 1;
        tick(4);
        spi_cs = 0;
        send_byte(8'($urandom));
        tick(18);
        @(negedge clk);
        tests_run++; if (frame_valid !== 1'b1) begin failed++; $display("FAIL bp_valid_held: got %b expected 1", frame_valid); end
        tests_run++; if (opcode !== op) begin failed++; $display("FAIL bp_opcode_held: got %h expected %h", opcode, op); end
        tests_run++; if (payload !== pl) begin failed++; $display("FAIL bp_payload_held: got %h expected %h", payload, pl); end
        tests_run++; if (n_ovr - b_ovr !== 3) begin failed++; $display("FAIL bp_overruns: got %0d expected 3", n_ovr - b_ovr); end
        tests_run++; if (n_abort - b_abort !== 0) begin failed++; $display("FAIL bp_cs_in_hold: got %0d expected 0", n_abort - b_abort); end
        tests_run++; if (got_op.size() !== b_frames) begin failed++; $display("FAIL bp_early_transfer: got %0d expected 0", got_op.size() - b_frames); end
        tick(1);
        frame_ready = 1;
        tick(1);
        @(negedge clk);
        tests_run++; if (frame_valid !== 1'b0) begin failed++; $display("FAIL bp_valid_drop: got %b expected 0", frame_valid); end
        tests_run++;
        if (got_op.size() !== b_frames + 1) begin
            failed++; $display("FAIL bp_count: got %0d expected 1", got_op.size() - b_frames);
        end else begin
            tests_run++; if (got_pl[rd_idx] !== pl) begin failed++; $display("FAIL bp_payload: got %h expected %h", got_pl[rd_idx], pl); end
            rd_idx = got_op.size();
        end
        tick(2);
    endtask

    task automatic test_abort();
        logic [PW-1:0] pl;
        logic [7:0]    op;
        snap();
        frame_ready = 1;
        tx_q.push_back(HDR);
        tx_q.push_back(8'h07);
        for (int i = 0; i < 6; i++) tx_q.push_back(8'($urandom));
        send_q();
        spi_cs = 1;
        tick(6);
        spi_cs = 0;
        tick(6);
        tests_run++; if (n_abort - b_abort !== 1) begin failed++; $display("FAIL abort_pulses: got %0d expected 1", n_abort - b_abort); end
        tests_run++; if (n_chk - b_chk !== 0) begin failed++; $display("FAIL abort_no_chk: got %0d expected 0", n_chk - b_chk); end
        op = 8'h02;
        pl = rand_pl();
        push_frame(op, pl, 8'h00);
        send_q();
        wait_frames(b_frames + 1);
        tests_run++;
        if (got_op.size() !== b_frames + 1) begin
            failed++; $display("FAIL abort_next_count: got %0d expected 1", got_op.size() - b_frames);
        end else begin
            tests_run++; if (got_op[rd_idx] !== 8'h02) begin failed++; $display("FAIL abort_next_opcode: got %h expected 02", got_op[rd_idx]); end
            tests_run++; if (got_pl[rd_idx] !== pl) begin failed++; $display("FAIL abort_next_payload: got %h expected %h", got_pl[rd_idx], pl); end
            rd_idx = got_op.size();
        end
    endtask

    task automatic test_garbage();
        logic [PW-1:0] pl;
        logic [7:0]    op;
        snap();
        op = 8'($urandom);
        pl = rand_pl();
        tx_q.push_back(8'h00);
        tx_q.push_back(8'hFF);
        tx_q.push_back(8'h5A);
        push_frame(op, pl, 8'h00);
        send_q();
        wait_frames(b_frames + 1);
        tests_run++;
        if (got_op.size() !== b_frames + 1) begin
            failed++; $display("FAIL garbage_count: got %0d expected 1", got_op.size() - b_frames);
        end else begin
            tests_run++; if (got_op[rd_idx] !== op) begin failed++; $display("FAIL garbage_opcode: got %h expected %h", got_op[rd_idx], op); end
            tests_run++; if (got_pl[rd_idx] !== pl) begin failed++; $display("FAIL garbage_payload: got %h expected %h", got_pl[rd_idx], pl); end
            rd_idx = got_op.size();
        end
        tests_run++; if (n_chk + n_abort + n_ovr - b_chk - b_abort - b_ovr !== 0) begin failed++; $display("FAIL garbage_no_pulses: got %0d expected 0", n_chk + n_abort + n_ovr - b_chk - b_abort - b_ovr); end
    endtask

    task automatic test_reset_mid();
        logic [PW-1:0] pl;
        logic [7:0]    op;
        tx_q.push_back(HDR);
        tx_q.push_back(8'h5C);
        for (int i = 0; i < 10; i++) tx_q.push_back(8'($urandom_range(1, 255)));
        send_q();
        rst = 1;
        @(posedge clk);
        #1;
        rst = 0;
        @(negedge clk);
        tests_run++; if (frame_valid !== 1'b0) begin failed++; $display("FAIL rstmid_valid: got %b expected 0", frame_valid); end
        tests_run++; if (opcode !== 8'h00) begin failed++; $display("FAIL rstmid_opcode: got %h expected 00", opcode); end
        tests_run++; if (payload !== '0) begin failed++; $display("FAIL rstmid_payload: got %h expected 0", payload); end
        tests_run++; if ({chk_err, abort, overrun} !== 3'b000) begin failed++; $display("FAIL rstmid_pulses: got %b expected 000", {chk_err, abort, overrun}); end
        tick(2);
        snap();
        op = 8'($urandom);
        pl = rand_pl();
        push_frame(op, pl, 8'h00);
        send_q();
        wait_frames(b_frames + 1);
        tests_run++;
        if (got_op.size() !== b_frames + 1) begin
            failed++; $display("FAIL rstmid_next_count: got %0d expected 1", got_op.size() - b_frames);
        end else begin
            tests_run++; if (got_op[rd_idx] !== op) begin failed++; $display("FAIL rstmid_next_opcode: got %h expected %h", got_op[rd_idx], op); end
            tests_run++; if (got_pl[rd_idx] !== pl) begin failed++; $display("FAIL rstmid_next_payload: got %h expected %h", got_pl[rd_idx], pl); end
            rd_idx = got_op.size();
        end
    endtask

    task automatic test_random();
        logic [PW-1:0] pl;
        logic [7:0]    op, g, corrupt;
        int            delay, ngarb;
        for (int it = 0; it < 10; it++) begin
            snap();
            op      = 8'($urandom);
            pl      = rand_pl();
            corrupt = ($urandom % 3 == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
            delay   = $urandom_range(0, 20);
            ngarb   = $urandom_range(0, 2);
            for (int i = 0; i < ngarb; i++) begin
                g = 8'($urandom);
                if (g == HDR) g = 8'h00;
                tx_q.push_back(g);
            end
            if ($urandom % 2 == 0) begin
                spi_cs = 1;
                tick(5);
                spi_cs = 0;
                tick(3);
            end
            push_frame(op, pl, corrupt);
            frame_ready = (delay == 0);
            send_q();
            if (corrupt != 8'h00) begin
                tick(4);
                tests_run++; if (n_chk - b_chk !== 1) begin failed++; $display("FAIL rand%0d_chk: got %0d expected 1", it, n_chk - b_chk); end
                tests_run++; if (got_op.size() !== b_frames) begin failed++; $display("FAIL rand%0d_dropped: got %0d expected 0", it, got_op.size() - b_frames); end
            end else begin
                if (delay > 0) begin
                    wait_valid();
                    tick(delay);
                    frame_ready = 1;
                end
                wait_frames(b_frames + 1);
                tests_run++;
                if (got_op.size() !== b_frames + 1) begin
                    failed++; $display("FAIL rand%0d_count: got %0d expected 1", it, got_op.size() - b_frames);
                end else begin
                    tests_run++; if (got_op[rd_idx] !== op) begin failed++; $display("FAIL rand%0d_opcode: got %h expected %h", it, got_op[rd_idx], op); end
                    tests_run++; if (got_pl[rd_idx] !== pl) begin failed++; $display("FAIL rand%0d_payload: got %h expected %h", it, got_pl[rd_idx], pl); end
                    rd_idx = got_op.size();
                end
                tests_run++; if (n_chk - b_chk !== 0) begin failed++; $display("FAIL rand%0d_no_chk: got %0d expected 0", it, n_chk - b_chk); end
            end
            tests_run++; if (n_abort - b_abort !== 0) begin failed++; $display("FAIL rand%0d_no_abort: got %0d expected 0", it, n_abort - b_abort); end
            tick(2);
        end
        frame_ready = 1;
    endtask

    task automatic test_protocol();
        tests_run++; if (n_wid_err !== 0) begin failed++; $display("FAIL pulse_width: got %0d wide pulses expected 0", n_wid_err); end
        tests_run++; if (n_stab_err !== 0) begin failed++; $display("FAIL hold_stability: got %0d changes expected 0", n_stab_err); end
        tests_run++; if (n_drop_err !== 0) begin failed++; $display("FAIL valid_after_transfer: got %0d cycles expected 0", n_drop_err); end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_good_frame();
        test_bad_checksum();
        test_back_pressure();
        test_abort();
        test_garbage();
        test_reset_mid();
        test_random();
        test_protocol();
        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end

endmodule
